// File: rtl/sobel_gradient_gen.sv
// -----------------------------------------------------------------------------
// sobel_gradient_gen
//
// Streaming 3x3 Sobel stage. Consumes 8-bit grayscale pixels in row-major
// order and produces one signed (gx, gy) pair for every interior pixel of the
// frame, i.e. (IMG_W-2)*(IMG_H-2) pairs per frame. Results feed
// total_gradient.
//
// Parameters
//   IMG_W, IMG_H : image width / height in pixels (both >= 3)
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_pixel / in_sof are valid this cycle
//   in_ready   : block accepts a pixel this cycle (!out_valid || out_ready)
//   in_pixel   : unsigned 8-bit pixel
//   in_sof     : this pixel is (0,0) of a new frame (resynchronises counters)
//   out_valid  : out_gx / out_gy hold a gradient pair
//   out_ready  : downstream takes the pair this cycle
//   out_gx     : signed 11-bit horizontal gradient
//   out_gy     : signed 11-bit vertical gradient
//   out_last   : (only with SOBEL_FRAME_LAST_EN defined) marks the final pair
//                of the frame, centre (IMG_H-2, IMG_W-2)
//
// Optional feature macro: SOBEL_FRAME_LAST_EN
// -----------------------------------------------------------------------------
module sobel_gradient_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_pixel,
    input  logic               in_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [10:0] out_gx,
    output logic signed [10:0] out_gy
`ifdef SOBEL_FRAME_LAST_EN
    ,
    output logic               out_last
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic out_valid_reg;
    logic accept;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Position of the pixel being offered. in_sof overrides the counters so a
    // resync always lands on (0,0); the row<2 gate then suppresses any window
    // that would mix old and new frame data.
    // -------------------------------------------------------------------------
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic [CW-1:0] col_next;
    logic [RW-1:0] row_next;
    logic          col_last;
    logic          row_last;

    always_comb begin
        pos_col  = in_sof ? '0 : col_reg;
        pos_row  = in_sof ? '0 : row_reg;
        col_last = (pos_col == CW'(IMG_W - 1));
        row_last = (pos_row == RW'(IMG_H - 1));
        col_next = col_last ? '0 : pos_col + 1'b1;
        if (col_last) begin
            row_next = row_last ? '0 : pos_row + 1'b1;
        end else begin
            row_next = pos_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers. Tap 0 holds row r-1, tap 1 holds row r-2.
    //
    // Reads are registered, so the address is prefetched one cycle ahead: on
    // an accept we already read the column of the *next* pixel, otherwise we
    // keep reading the current column. Either way the read data is valid for
    // whatever pixel is accepted next. The write column (current) and the
    // prefetch column (next) never coincide because IMG_W >= 3.
    //
    // After an in_sof resync the prefetched data belongs to the old column,
    // which only corrupts row-0 history that is never used for an output.
    // -------------------------------------------------------------------------
    logic [CW-1:0] rd_addr;
    logic [7:0]    tap_rd [2];

    always_comb begin
        if (rst) begin
            rd_addr = '0;
        end else if (accept) begin
            rd_addr = col_next;
        end else begin
            rd_addr = col_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [7:0] mem [IMG_W];
            logic [7:0] rd_data_reg;
            logic [7:0] wr_data;

            // Tap 0 stores the incoming pixel; tap 1 stores what tap 0 held
            // at that column, i.e. the row that is now two rows back.
            assign wr_data = (gi == 0) ? in_pixel : tap_rd[0];

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[pos_col] <= wr_data;
                end
                rd_data_reg <= mem[rd_addr];
            end

            assign tap_rd[gi] = rd_data_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // 3x3 window. Index 0 = top row (r-2), 1 = middle (r-1), 2 = bottom (r).
    // The right column comes straight from the line-buffer taps and the
    // incoming pixel; the centre and left columns are shift registers.
    // -------------------------------------------------------------------------
    logic [7:0] win_r [3];
    logic [7:0] win_c_reg [3];
    logic [7:0] win_l_reg [3];

    assign win_r[0] = tap_rd[1];
    assign win_r[1] = tap_rd[0];
    assign win_r[2] = in_pixel;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                win_c_reg[i] <= '0;
                win_l_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_l_reg[i] <= win_c_reg[i];
                win_c_reg[i] <= win_r[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sobel arithmetic. Each 1-2-1 weighted sum is at most 4*255 = 1020, so an
    // 11-bit difference of two such sums covers +/-1020 without overflow.
    // -------------------------------------------------------------------------
    function automatic logic [10:0] wsum(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    logic signed [10:0] gx_next;
    logic signed [10:0] gy_next;
    logic               win_done;

    always_comb begin
        gx_next = wsum(win_r[0], win_r[1], win_r[2])
                - wsum(win_l_reg[0], win_l_reg[1], win_l_reg[2]);
        gy_next = wsum(win_l_reg[2], win_c_reg[2], win_r[2])
                - wsum(win_l_reg[0], win_c_reg[0], win_r[0]);
    end

    // A window is only complete once two earlier columns of the same row have
    // been accepted (c >= 2) and two earlier rows exist (r >= 2).
    assign win_done = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));

    // -------------------------------------------------------------------------
    // Output register: loads on a completed window, holds under backpressure.
    // A new load may coincide with the drain of the previous pair.
    // -------------------------------------------------------------------------
    logic signed [10:0] out_gx_reg;
    logic signed [10:0] out_gy_reg;
`ifdef SOBEL_FRAME_LAST_EN
    logic               out_last_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_gx_reg    <= '0;
            out_gy_reg    <= '0;
`ifdef SOBEL_FRAME_LAST_EN
            out_last_reg  <= 1'b0;
`endif
        end else if (win_done) begin
            out_valid_reg <= 1'b1;
            out_gx_reg    <= gx_next;
            out_gy_reg    <= gy_next;
`ifdef SOBEL_FRAME_LAST_EN
            // Centre (IMG_H-2, IMG_W-2) means the bottom-right frame pixel
            // has just completed the window.
            out_last_reg  <= row_last && col_last;
`endif
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_gx    = out_gx_reg;
    assign out_gy    = out_gy_reg;
`ifdef SOBEL_FRAME_LAST_EN
    assign out_last  = out_last_reg;
`endif

endmodule

// File: tb/tb_sobel_gradient_gen.sv
// -----------------------------------------------------------------------------
// tb_sobel_gradient_gen
//
// Two instances: a 3x3 one driven from a table of hand-computed windows, and
// an 8x8 one driven with whole frames (ramp, backpressure, in_sof resync,
// mid-frame reset). 8x8 expectations come from a direct convolution of the
// generated test image.
// -----------------------------------------------------------------------------
module tb_sobel_gradient_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_pixel;
    logic       in_sof;
    logic       out_ready;

    logic               in_valid3, in_ready3, out_valid3, last3;
    logic signed [10:0] gx3, gy3;
    logic               in_valid8, in_ready8, out_valid8, last8;
    logic signed [10:0] gx8, gy8;

`ifndef SOBEL_FRAME_LAST_EN
    assign last3 = 1'b0;
    assign last8 = 1'b0;
`endif

    sobel_gradient_gen #(.IMG_W(3), .IMG_H(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_gx    (gx3),
        .out_gy    (gy3)
`ifdef SOBEL_FRAME_LAST_EN
        ,
        .out_last  (last3)
`endif
    );

    sobel_gradient_gen #(.IMG_W(8), .IMG_H(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_gx    (gx8),
        .out_gy    (gy8)
`ifdef SOBEL_FRAME_LAST_EN
        ,
        .out_last  (last8)
`endif
    );

    // ---------------------------------------------------------------- monitors
    logic [22:0] q3[$];
    logic [22:0] q8[$];
    int          n8 = 0;

    always @(negedge clk) begin
        if (rst === 1'b0 && out_ready === 1'b1) begin
            if (out_valid3 === 1'b1) q3.push_back({last3, gx3, gy3});
            if (out_valid8 === 1'b1) begin
                q8.push_back({last8, gx8, gy8});
                n8 = n8 + 1;
            end
        end
    end

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------------------------------------------------------- model
    function automatic int pat(input int s, input int r, input int c);
        if (s == 0) return c * 10;
        return (r * 37 + c * 59 + r * c * 11 + s * 13) % 256;
    endfunction

    function automatic int exp_gx(input int s, input int r, input int c);
        return (pat(s, r-1, c+1) + 2*pat(s, r, c+1) + pat(s, r+1, c+1))
             - (pat(s, r-1, c-1) + 2*pat(s, r, c-1) + pat(s, r+1, c-1));
    endfunction

    function automatic int exp_gy(input int s, input int r, input int c);
        return (pat(s, r+1, c-1) + 2*pat(s, r+1, c) + pat(s, r+1, c+1))
             - (pat(s, r-1, c-1) + 2*pat(s, r-1, c) + pat(s, r-1, c+1));
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic send(input bit which, input logic [7:0] p, input logic sof);
        bit ok = 1'b0;
        in_pixel = p;
        in_sof   = sof;
        if (which) in_valid8 = 1'b1;
        else       in_valid3 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((which ? in_ready8 : in_ready3) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready never rose within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        in_valid8 = 1'b0;
        in_sof    = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic flush8();
        while (q8.size() > 0) void'(q8.pop_front());
    endtask

    // Sends npix pixels of test image s to the 8x8 instance. With bp set,
    // out_ready is held low for 5 cycles as soon as the 3rd pair is loaded.
    task automatic send_frame8(input int s, input bit sof0, input int npix, input bit bp);
        int base    = n8;
        bit bp_done = 1'b0;
        for (int i = 0; i < npix; i++) begin
            send(1'b1, 8'(pat(s, i / 8, i % 8)), sof0 && (i == 0));
            if (bp && !bp_done && out_valid8 === 1'b1 && (n8 - base) == 2) begin
                bp_done   = 1'b1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", int'(in_ready8), 0);
                    chk("bp_out_valid", int'(out_valid8), 1);
                    chk("bp_gx_hold", int'(gx8), exp_gx(s, 1, 3));
                    chk("bp_gy_hold", int'(gy8), exp_gy(s, 1, 3));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        end
        if (bp) chk("bp_engaged", int'(bp_done), 1);
    endtask

    // Compares the first nexp queued pairs with the model, in raster order.
    task automatic check_frame8(input int s, input int nexp, input string tag);
        logic [22:0] e;
        int r, c;
        chk({tag, "_count"}, q8.size(), nexp);
        for (int k = 0; k < nexp; k++) begin
            if (q8.size() == 0) break;
            e = q8.pop_front();
            r = 1 + k / 6;
            c = 1 + k % 6;
            chk({tag, "_gx"}, int'($signed(e[21:11])), exp_gx(s, r, c));
            chk({tag, "_gy"}, int'($signed(e[10:0])), exp_gy(s, r, c));
`ifdef SOBEL_FRAME_LAST_EN
            chk({tag, "_last"}, int'(e[22]), (r == 6 && c == 6) ? 1 : 0);
`endif
        end
        flush8();
        $display("frame %s: image %0d, %0d pairs checked", tag, s, nexp);
    endtask

    // ---------------------------------------------------------------- 3x3 table
    typedef struct packed {
        logic [8:0][7:0]    pix;   // raster order, element 8 first
        logic signed [10:0] gx;
        logic signed [10:0] gy;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [22:0] e;

        tbl[0] = '{pix: {8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100},
                   gx: 11'sd0, gy: 11'sd0};
        tbl[1] = '{pix: {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255},
                   gx: 11'sd1020, gy: 11'sd0};
        tbl[2] = '{pix: {8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0},
                   gx: -11'sd1020, gy: 11'sd0};
        tbl[3] = '{pix: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255},
                   gx: 11'sd0, gy: 11'sd1020};
        tbl[4] = '{pix: {8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                   gx: 11'sd0, gy: -11'sd1020};
        tbl[5] = '{pix: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9},
                   gx: 11'sd8, gy: 11'sd24};
        tbl[6] = '{pix: {8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd0},
                   gx: 11'sd100, gy: -11'sd20};

        rst       = 1'b1;
        in_valid3 = 1'b0;
        in_valid8 = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid3", int'(out_valid3), 0);
        chk("rst_gx3", int'(gx3), 0);
        chk("rst_gy3", int'(gy3), 0);
        chk("rst_in_ready3", int'(in_ready3), 1);
        chk("rst_out_valid8", int'(out_valid8), 0);
        chk("rst_in_ready8", int'(in_ready8), 1);

        // 3x3 table: one pair per frame; odd frames also assert in_sof on the
        // pixel where the counters wrap anyway.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 9; i++) begin
                send(1'b0, tbl[v].pix[8 - i], (v % 2 == 1) && (i == 0));
                if (v == 0 && i == 7) chk("lat_before_9th", int'(out_valid3), 0);
                if (v == 0 && i == 8) chk("lat_after_9th", int'(out_valid3), 1);
            end
            drain();
            chk("tbl_count", q3.size(), 1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("tbl_gx", int'($signed(e[21:11])), int'($signed(tbl[v].gx)));
                chk("tbl_gy", int'($signed(e[10:0])), int'($signed(tbl[v].gy)));
`ifdef SOBEL_FRAME_LAST_EN
                chk("tbl_last", int'(e[22]), 1);
`endif
                $display("vec %0d: gx=%0d gy=%0d", v, $signed(e[21:11]), $signed(e[10:0]));
            end
            while (q3.size() > 0) void'(q3.pop_front());
        end

        // 8x8 ramp (pixel = col*10): every pair gx=80, gy=0.
        send_frame8(0, 1'b0, 64, 1'b0);
        drain();
        check_frame8(0, 36, "ramp");

        // Backpressure on the 3rd pair; in_sof coincides with the natural wrap.
        send_frame8(1, 1'b1, 64, 1'b1);
        drain();
        check_frame8(1, 36, "bp");

        // 20 pixels, then resync with in_sof into a complete frame.
        send_frame8(2, 1'b1, 20, 1'b0);
        drain();
        check_frame8(2, 2, "sof_part");
        send_frame8(3, 1'b1, 64, 1'b0);
        drain();
        check_frame8(3, 36, "sof_new");

        // Reset in the middle of a frame, then a complete frame without in_sof.
        send_frame8(4, 1'b1, 30, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid8", int'(out_valid8), 0);
        chk("midrst_gx8", int'(gx8), 0);
        chk("midrst_in_ready8", int'(in_ready8), 1);
        flush8();
        send_frame8(5, 1'b0, 64, 1'b0);
        drain();
        check_frame8(5, 36, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
